// File: rtl/regdesloc_univ.sv
// Parametrised universal shift register with rotate, arithmetic
// shift, serial tap and an autonomous WIDTH-bit serial burst.
module regdesloc_univ #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic             in_serial,
  input  logic [WIDTH-1:0] in_paralelo,
  output logic [WIDTH-1:0] outreg,
  output logic             out_serial,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = '0;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_SHL   = 3'd1;
  localparam logic [2:0] OP_SHR   = 3'd2;
  localparam logic [2:0] OP_LOAD  = 3'd3;
  localparam logic [2:0] OP_ROL   = 3'd4;
  localparam logic [2:0] OP_ROR   = 3'd5;
  localparam logic [2:0] OP_ASR   = 3'd6;
  localparam logic [2:0] OP_BURST = 3'd7;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] shl_v, shr_v;
  logic [WIDTH-1:0] rol_v, ror_v;
  logic [WIDTH-1:0] asr_v, burst_v;

  // Candidate results for every shift flavour
  always_comb begin
    shl_v   = {reg_q[WIDTH-2:0], in_serial};
    shr_v   = {in_serial, reg_q[WIDTH-1:1]};
    rol_v   = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
    ror_v   = {reg_q[0], reg_q[WIDTH-1:1]};
    asr_v   = {reg_q[WIDTH-1], reg_q[WIDTH-1:1]};
    burst_v = MSB_FIRST ? shl_v : shr_v;
  end

  // State, counter, data and done flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      reg_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      reg_q   <= reg_d;
      done_q  <= done_d;
    end
  end

  // Next-state: burst entry from idle, exit on final shift
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (op == OP_BURST) state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == CNT_ONE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: op decode when idle, serial shift when bursting
  always_comb begin
    reg_d  = reg_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = CNT_ZERO;
        unique case (op)
          OP_NOP:   reg_d = reg_q;
          OP_SHL:   reg_d = shl_v;
          OP_SHR:   reg_d = shr_v;
          OP_LOAD:  reg_d = in_paralelo;
          OP_ROL:   reg_d = rol_v;
          OP_ROR:   reg_d = ror_v;
          OP_ASR:   reg_d = asr_v;
          OP_BURST: cnt_d = CNT_FULL;
          default:  reg_d = reg_q;
        endcase
      end
      SHIFT: begin
        reg_d = burst_v;
        if (cnt_q != CNT_ZERO) cnt_d = cnt_q - CNT_ONE;
        done_d = (cnt_q == CNT_ONE);
      end
      default: begin
        cnt_d = CNT_ZERO;
      end
    endcase
  end

  // Outputs: registered status plus the serial tap
  always_comb begin
    outreg     = reg_q;
    busy       = (state_q == SHIFT);
    done       = done_q;
    out_serial = MSB_FIRST ? reg_q[WIDTH-1] : reg_q[0];
  end

endmodule

// File: tb/tb_regdesloc_univ.sv
// Bench for regdesloc_univ: directed plan steps followed by random
// ops, all compared against an arithmetic reference model.
module tb_regdesloc_univ;

  localparam int W   = 8;
  localparam bit MSB = 1'b1;
  localparam longint M = 64'd1 << W;
  localparam longint H = M / 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   op;
  logic         in_serial;
  logic [W-1:0] in_paralelo;
  logic [W-1:0] outreg;
  logic         out_serial;
  logic         busy;
  logic         done;

  int vectors = 0;
  int miss    = 0;

  longint m_reg  = 0;
  int     m_left = 0;
  bit     m_busy = 0;
  bit     m_done = 0;

  regdesloc_univ #(.WIDTH(W), .MSB_FIRST(MSB)) dut (
    .clk(clk),
    .rst(rst),
    .op(op),
    .in_serial(in_serial),
    .in_paralelo(in_paralelo),
    .outreg(outreg),
    .out_serial(out_serial),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_reg = 0; m_left = 0; m_busy = 0; m_done = 0;
  endtask

  task automatic model_edge(input int o, input int s, input longint p);
    if (m_busy) begin
      if (MSB) m_reg = (m_reg * 2) % M + s;
      else     m_reg = m_reg / 2 + s * H;
      m_left = m_left - 1;
      m_done = (m_left == 0);
      m_busy = (m_left != 0);
    end else begin
      m_done = 0;
      case (o)
        1: m_reg = (m_reg * 2) % M + s;
        2: m_reg = m_reg / 2 + s * H;
        3: m_reg = p % M;
        4: m_reg = (m_reg * 2) % M + m_reg / H;
        5: m_reg = m_reg / 2 + (m_reg % 2) * H;
        6: m_reg = m_reg / 2 + ((m_reg >= H) ? H : 0);
        7: begin m_busy = 1; m_left = W; end
        default: ;
      endcase
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".outreg"}, longint'(outreg), m_reg);
    chk({tag, ".busy"}, longint'(busy), longint'(m_busy));
    chk({tag, ".done"}, longint'(done), longint'(m_done));
    chk({tag, ".sout"}, longint'(out_serial),
        MSB ? m_reg / H : m_reg % 2);
  endtask

  task automatic step(input string tag, input logic [2:0] o,
                      input logic s, input logic [W-1:0] p);
    op = o; in_serial = s; in_paralelo = p;
    model_edge(int'(o), int'(s), longint'(p));
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  initial begin
    bit sin_seq[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    bit sout_exp[8] = '{1, 1, 0, 0, 0, 0, 1, 1};
    bit sout_obs[8];
    int bcnt;
    logic [2:0] lo;

    rst = 1'b0; op = 3'd0; in_serial = 1'b0; in_paralelo = '0;
    model_reset();
    #12 rst = 1'b1;

    // Asynchronous reset mid-cycle
    step("load_ff", 3'd3, 1'b0, 8'hFF);
    chk("pre_rst", longint'(outreg), 64'hFF);
    #3 rst = 1'b0;
    model_reset();
    #1 chk_all("async_rst");
    #2 rst = 1'b1;
    step("nop_after_rst", 3'd0, 1'b0, 8'h00);
    chk("rst_hold", longint'(outreg), 64'h00);

    // Basic ops
    step("load_a5", 3'd3, 1'b0, 8'hA5);
    chk("load_a5_lit", longint'(outreg), 64'hA5);
    step("shl", 3'd1, 1'b1, 8'h00);
    chk("shl_lit", longint'(outreg), 64'h4B);
    step("load_a5b", 3'd3, 1'b0, 8'hA5);
    step("shr", 3'd2, 1'b0, 8'h00);
    chk("shr_lit", longint'(outreg), 64'h52);
    step("nop", 3'd0, 1'b1, 8'hFF);
    chk("nop_lit", longint'(outreg), 64'h52);

    // Rotate / arithmetic
    step("load_01", 3'd3, 1'b0, 8'h01);
    step("ror", 3'd5, 1'b1, 8'h00);
    chk("ror_lit", longint'(outreg), 64'h80);
    step("asr", 3'd6, 1'b0, 8'h00);
    chk("asr_lit", longint'(outreg), 64'hC0);
    step("rol", 3'd4, 1'b1, 8'h00);
    chk("rol_lit", longint'(outreg), 64'h81);
    step("rol0", 3'd4, 1'b0, 8'h00);
    chk("rol0_lit", longint'(outreg), 64'h03);

    // Burst
    step("load_c3", 3'd3, 1'b0, 8'hC3);
    step("burst_go", 3'd7, 1'b0, 8'h00);
    bcnt = 0;
    for (int i = 0; i < 8; i++) begin
      sout_obs[i] = out_serial;
      if (busy) bcnt++;
      step("burst", 3'd0, logic'(sin_seq[i]), 8'h00);
    end
    chk("burst_busy_cycles", bcnt, 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("burst_sout%0d", i), longint'(sout_obs[i]),
          longint'(sout_exp[i]));
    chk("burst_result", longint'(outreg), 64'hB2);
    chk("burst_done", longint'(done), 1);
    step("after_done", 3'd0, 1'b0, 8'h00);
    chk("done_pulse", longint'(done), 0);

    // Busy lockout then back-to-back restart
    step("load_c3b", 3'd3, 1'b0, 8'hC3);
    step("burst2_go", 3'd7, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      lo = (i == 2) ? 3'd3 : (i == 4) ? 3'd7 : 3'd0;
      step("lockout", lo, logic'(sin_seq[i]), 8'hFF);
    end
    chk("lockout_result", longint'(outreg), 64'hB2);
    chk("lockout_done", longint'(done), 1);
    step("b2b_go", 3'd7, 1'b0, 8'h00);
    chk("b2b_busy", longint'(busy), 1);
    chk("b2b_done", longint'(done), 0);
    for (int i = 0; i < 8; i++)
      step("b2b", 3'd0, logic'($urandom_range(1)), 8'h00);
    step("b2b_end", 3'd0, 1'b0, 8'h00);

    // Reset mid-burst
    step("load_rb", 3'd3, 1'b0, 8'h3C);
    step("rb_go", 3'd7, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++)
      step("rb_shift", 3'd0, 1'b1, 8'h00);
    #2 rst = 1'b0;
    model_reset();
    #1 chk_all("rst_mid_burst");
    #2 rst = 1'b1;
    step("rb_nop", 3'd0, 1'b0, 8'h00);
    chk("rb_no_done", longint'(done), 0);
    step("load_5a", 3'd3, 1'b0, 8'h5A);
    chk("load_5a_lit", longint'(outreg), 64'h5A);

    // Random ops against the model
    for (int i = 0; i < 400; i++) begin
      lo = 3'($urandom_range(7));
      if (lo == 3'd7 && $urandom_range(3) != 0) lo = 3'd3;
      step("rand", lo, logic'($urandom_range(1)),
           W'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miss);
    $finish;
  end

endmodule
